// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner: drives one column low at a time, assembles raw frames and publishes a debounced 64-bit snapshot.
// Optional ghost detection (adds o_ghost) is enabled by defining MATRIX_SCAN_GHOST_EN.
module key_matrix_scanner #(
  parameter int SCAN_DIV        = 8000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        i_clk,
  input  logic        i_nreset,
  input  logic [7:0]  i_rows,
  output logic [7:0]  o_cols,
  output logic [63:0] o_vals,
  output logic        o_frame,
  output logic        o_changed
`ifdef MATRIX_SCAN_GHOST_EN
  ,
  output logic        o_ghost
`endif
);

  localparam int             DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB      = 4'(DEBOUNCE_FRAMES);

  logic [7:0]       sync1, sync2;
  logic [DIV_W-1:0] div;
  logic [2:0]       col;
  logic [63:0]      raw, prev;
  logic [3:0]       stable;

  logic        sample, frame_end, ghost, publish;
  logic [63:0] raw_next;
  logic [3:0]  stable_next;

  // NOTE: every variable is given a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    raw_next    = raw;
    sample      = (div == DIV_LAST);
    frame_end   = sample && (col == 3'd7);
    if (sample) raw_next[col*8 +: 8] = ~sync2;

    if (raw_next == prev) stable_next = (stable >= DEB) ? DEB : stable + 4'd1;
    else                  stable_next = 4'd1;
  end

`ifdef MATRIX_SCAN_GHOST_EN
  // Two columns sharing two or more pressed rows make the frame ambiguous.
  always_comb begin
    logic [7:0] both;
    both  = '0;
    ghost = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        both = raw_next[i*8 +: 8] & raw_next[j*8 +: 8];
        if ((both & (both - 8'd1)) != 8'd0) ghost = 1'b1;
      end
    end
  end
`else
  assign ghost = 1'b0;
`endif

  assign publish = (stable_next >= DEB) && (raw_next != o_vals) && !ghost;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      sync1     <= 8'hFF;
      sync2     <= 8'hFF;
      div       <= '0;
      col       <= 3'd0;
      o_cols    <= 8'hFE;
      raw       <= '0;
      prev      <= '0;
      stable    <= 4'd0;
      o_vals    <= '0;
      o_frame   <= 1'b0;
      o_changed <= 1'b0;
    end else begin
      sync1     <= i_rows;
      sync2     <= sync1;
      raw       <= raw_next;
      o_frame   <= frame_end;
      o_changed <= frame_end && publish;

      if (sample) begin
        div    <= '0;
        col    <= col + 3'd1;
        o_cols <= {o_cols[6:0], o_cols[7]};
      end else begin
        div <= div + DIV_W'(1);
      end

      if (frame_end) begin
        prev   <= raw_next;
        stable <= stable_next;
        if (publish) o_vals <= raw_next;
      end
    end
  end

`ifdef MATRIX_SCAN_GHOST_EN
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset)      o_ghost <= 1'b0;
    else if (frame_end) o_ghost <= ghost;
  end
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed self-checking bench for key_matrix_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2 (32-cycle frames).
module tb_key_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rows;
  logic [7:0]  cols;
  logic [63:0] vals;
  logic        frame, changed;
  logic [63:0] keys = '0;
  int          total = 0;
  int          bad   = 0;
`ifdef MATRIX_SCAN_GHOST_EN
  logic        ghost;
`endif

  key_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .i_clk    (clk),
    .i_nreset (rst_n),
    .i_rows   (rows),
    .o_cols   (cols),
    .o_vals   (vals),
    .o_frame  (frame),
    .o_changed(changed)
`ifdef MATRIX_SCAN_GHOST_EN
    ,
    .o_ghost  (ghost)
`endif
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed key pulls its row low while its column is driven.
  always @(cols or keys) begin
    logic [7:0] r;
    r = 8'hFF;
    for (int c = 0; c < 8; c++)
      if (!cols[c]) r = r & ~keys[c*8 +: 8];
    rows = r;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (frame) got = 1'b1;
    end
    check({tag, "_frame_seen"}, 64'(got), 64'd1);
  endtask

  task automatic restart(input logic [63:0] k);
    rst_n = 1'b0;
    keys  = k;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_cols;
    rows = 8'hFF;

    // 1: idle scan after reset
    repeat (2) @(negedge clk);
    check("rst_cols", 64'(cols), 64'hFE);
    check("rst_vals", vals, 64'h0);
    check("rst_frame", 64'(frame), 64'd0);
    check("rst_changed", 64'(changed), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      exp_cols = 8'hFF & ~(8'd1 << ((k / 4) % 8));
      check($sformatf("idle_cols_%0d", k), 64'(cols), 64'(exp_cols));
      check($sformatf("idle_frame_%0d", k), 64'(frame), 64'((k == 32) || (k == 64)));
      check($sformatf("idle_changed_%0d", k), 64'(changed), 64'd0);
      check($sformatf("idle_vals_%0d", k), vals, 64'h0);
      @(negedge clk);
    end

    // 2: key (2,5) held from frame 0, published at end of frame 1
    restart(64'h0000_0000_0020_0000);
    wait_frame("k25_f0");
    check("k25_f0_changed", 64'(changed), 64'd0);
    check("k25_f0_vals", vals, 64'h0);
    wait_frame("k25_f1");
    check("k25_f1_changed", 64'(changed), 64'd1);
    check("k25_f1_vals", vals, 64'h0000_0000_0020_0000);
    wait_frame("k25_f2");
    check("k25_f2_changed", 64'(changed), 64'd0);
    check("k25_f2_vals", vals, 64'h0000_0000_0020_0000);

    // 3: one-frame glitch never published
    restart(64'h0000_0000_0020_0000);
    wait_frame("gl_f0");
    keys = '0;
    for (int f = 1; f <= 3; f++) begin
      wait_frame($sformatf("gl_f%0d", f));
      check($sformatf("gl_f%0d_changed", f), 64'(changed), 64'd0);
      check($sformatf("gl_f%0d_vals", f), vals, 64'h0);
    end

    // 4: corner keys, publish then release
    restart(64'h8000_0000_0000_0001);
    wait_frame("cor_f0");
    check("cor_f0_changed", 64'(changed), 64'd0);
    wait_frame("cor_f1");
    check("cor_f1_changed", 64'(changed), 64'd1);
    check("cor_f1_vals", vals, 64'h8000_0000_0000_0001);
    keys = '0;
    wait_frame("cor_f2");
    check("cor_f2_changed", 64'(changed), 64'd0);
    check("cor_f2_vals", vals, 64'h8000_0000_0000_0001);
    wait_frame("cor_f3");
    check("cor_f3_changed", 64'(changed), 64'd1);
    check("cor_f3_vals", vals, 64'h0);
    wait_frame("cor_f4");
    check("cor_f4_changed", 64'(changed), 64'd0);

    // 5: reset mid-frame while o_vals is 1
    restart(64'h1);
    wait_frame("mr_f0");
    wait_frame("mr_f1");
    check("mr_pre_vals", vals, 64'h1);
    repeat (10) @(negedge clk);
    check("mr_pre_cols", 64'(cols), 64'hFB);
    rst_n = 1'b0;
    #1;
    check("mr_cols", 64'(cols), 64'hFE);
    check("mr_vals", vals, 64'h0);
    check("mr_frame", 64'(frame), 64'd0);
    check("mr_changed", 64'(changed), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_rel_cols", 64'(cols), 64'hFE);
    repeat (4) @(negedge clk);
    check("mr_col1", 64'(cols), 64'hFD);
    wait_frame("mr_f0b");
    check("mr_f0b_vals", vals, 64'h0);
    wait_frame("mr_f1b");
    check("mr_f1b_vals", vals, 64'h1);

`ifdef MATRIX_SCAN_GHOST_EN
    // 6: ghost rectangle blocks publishing until it is broken
    restart(64'h0000_0000_0600_0006);
    check("gh_rst", 64'(ghost), 64'd0);
    wait_frame("gh_f0");
    check("gh_f0_ghost", 64'(ghost), 64'd1);
    check("gh_f0_changed", 64'(changed), 64'd0);
    wait_frame("gh_f1");
    check("gh_f1_ghost", 64'(ghost), 64'd1);
    check("gh_f1_changed", 64'(changed), 64'd0);
    check("gh_f1_vals", vals, 64'h0);
    keys = 64'h0000_0000_0200_0006;
    wait_frame("gh_f2");
    check("gh_f2_ghost", 64'(ghost), 64'd0);
    check("gh_f2_changed", 64'(changed), 64'd0);
    wait_frame("gh_f3");
    check("gh_f3_changed", 64'(changed), 64'd1);
    check("gh_f3_vals", vals, 64'h0000_0000_0200_0006);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
